// File: rtl/write_channel_axi.sv
// write_channel_axi
//   Single-beat AXI4 write master for the cache back end. It accepts one word
//   write from the cache controller, drives AW and W independently, collects
//   the B response, and reissues the same write after an error response up
//   to CACHE_WRITE_MAX_RETRY times.
//
// Ports
//   ap_clk, reset          clock, asynchronous active-high reset
//   write_valid/ready      front-end request handshake (accepted in IDLE only)
//   write_addr             word address (byte address without offset bits)
//   write_wdata/wstrb      write data and byte enables
//   write_done             one-cycle pulse: write completed with OKAY
//   write_error            one-cycle pulse: write abandoned, retries exhausted
//   m_axi_aw*              write address channel (single beat, INCR)
//   m_axi_w*               write data channel (wlast == wvalid)
//   m_axi_b*               write response channel (bid ignored)
module write_channel_axi #(
  parameter int         CACHE_BACKEND_ADDR_W  = 32,
  parameter int         CACHE_BACKEND_DATA_W  = 32,
  parameter int         CACHE_BACKEND_NBYTES  = CACHE_BACKEND_DATA_W / 8,
  parameter int         CACHE_BACKEND_BYTE_W  = $clog2(CACHE_BACKEND_NBYTES),
  parameter int         CACHE_AXI_ID_W        = 1,
  parameter int         CACHE_AXI_ID          = 0,
  parameter logic [3:0] CACHE_AXI_CACHE_MODE  = 4'b0011,
  parameter int         CACHE_WRITE_MAX_RETRY = 3
) (
  input  logic                                           ap_clk,
  input  logic                                           reset,
  input  logic                                           write_valid,
  output logic                                           write_ready,
  input  logic [CACHE_BACKEND_ADDR_W-CACHE_BACKEND_BYTE_W-1:0] write_addr,
  input  logic [CACHE_BACKEND_DATA_W-1:0]                write_wdata,
  input  logic [CACHE_BACKEND_NBYTES-1:0]                write_wstrb,
  output logic                                           write_done,
  output logic                                           write_error,
  output logic                                           m_axi_awvalid,
  input  logic                                           m_axi_awready,
  output logic [CACHE_BACKEND_ADDR_W-1:0]                m_axi_awaddr,
  output logic [CACHE_AXI_ID_W-1:0]                      m_axi_awid,
  output logic [7:0]                                     m_axi_awlen,
  output logic [2:0]                                     m_axi_awsize,
  output logic [1:0]                                     m_axi_awburst,
  output logic                                           m_axi_awlock,
  output logic [3:0]                                     m_axi_awcache,
  output logic [2:0]                                     m_axi_awprot,
  output logic [3:0]                                     m_axi_awqos,
  output logic                                           m_axi_wvalid,
  input  logic                                           m_axi_wready,
  output logic [CACHE_BACKEND_DATA_W-1:0]                m_axi_wdata,
  output logic [CACHE_BACKEND_NBYTES-1:0]                m_axi_wstrb,
  output logic                                           m_axi_wlast,
  input  logic                                           m_axi_bvalid,
  output logic                                           m_axi_bready,
  input  logic [1:0]                                     m_axi_bresp,
  input  logic [CACHE_AXI_ID_W-1:0]                      m_axi_bid
);

  localparam int RETRY_W = (CACHE_WRITE_MAX_RETRY > 0) ? $clog2(CACHE_WRITE_MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] MAX_CNT = RETRY_W'(CACHE_WRITE_MAX_RETRY);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t                                           r_state;
  state_t                                           w_state_nxt;
  logic                                             r_aw_done;
  logic                                             r_w_done;
  logic [RETRY_W-1:0]                               r_retry_cnt;
  logic                                             r_done;
  logic                                             r_error;
  logic [CACHE_BACKEND_ADDR_W-CACHE_BACKEND_BYTE_W-1:0] r_addr_q;
  logic [CACHE_BACKEND_DATA_W-1:0]                  r_data_q;
  logic [CACHE_BACKEND_NBYTES-1:0]                  r_strb_q;

  logic w_accept;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_fin;
  logic w_w_fin;
  logic w_okay;
  logic w_can_retry;
  logic w_unused_bid;

  assign w_accept    = write_valid & write_ready;
  assign w_aw_hs     = m_axi_awvalid & m_axi_awready;
  assign w_w_hs      = m_axi_wvalid & m_axi_wready;
  // A channel counts as finished if it completed earlier or completes now.
  assign w_aw_fin    = r_aw_done | w_aw_hs;
  assign w_w_fin     = r_w_done | w_w_hs;
  assign w_okay      = (m_axi_bresp == 2'b00);
  assign w_can_retry = (r_retry_cnt < MAX_CNT);
  assign w_unused_bid = ^m_axi_bid;

  // Constant attributes of a single-beat INCR write.
  assign m_axi_awaddr  = {r_addr_q, {CACHE_BACKEND_BYTE_W{1'b0}}};
  assign m_axi_awid    = CACHE_AXI_ID_W'(CACHE_AXI_ID);
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'(CACHE_BACKEND_BYTE_W);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = CACHE_AXI_CACHE_MODE;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_wdata   = r_data_q;
  assign m_axi_wstrb   = r_strb_q;
  assign m_axi_wlast   = m_axi_wvalid;
  assign write_done    = r_done;
  assign write_error   = r_error;

  // ---- state register ----
  always_ff @(posedge ap_clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_aw_fin && w_w_fin) w_state_nxt = S_RESP;
      S_RESP: begin
        if (m_axi_bvalid) begin
          if (!w_okay && w_can_retry) w_state_nxt = S_ISSUE;
          else                        w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- output logic ----
  // write_ready is gated by reset so the front end sees no accept while the
  // block is held in reset even though the state already reads IDLE.
  always_comb begin
    write_ready   = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    unique case (r_state)
      S_IDLE:  write_ready   = ~reset;
      S_ISSUE: begin
        m_axi_awvalid = ~r_aw_done;
        m_axi_wvalid  = ~r_w_done;
      end
      S_RESP:  m_axi_bready  = 1'b1;
      default: ;
    endcase
  end

  // ---- handshake flags, retry counter, completion pulses ----
  always_ff @(posedge ap_clk or posedge reset) begin
    if (reset) begin
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_retry_cnt <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_retry_cnt <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
        end
        S_RESP: begin
          if (m_axi_bvalid) begin
            if (w_okay) begin
              r_done <= 1'b1;
            end else if (w_can_retry) begin
              // Reissue both channels with the same registered payload.
              r_retry_cnt <= r_retry_cnt + 1'b1;
              r_aw_done   <= 1'b0;
              r_w_done    <= 1'b0;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---- request payload capture (held stable for all attempts) ----
  always_ff @(posedge ap_clk) begin
    if (w_accept) begin
      r_addr_q <= write_addr;
      r_data_q <= write_wdata;
      r_strb_q <= write_wstrb;
    end
  end

endmodule

// File: tb/tb_write_channel_axi.sv
module tb_write_channel_axi;

  localparam int MAX_RETRY = 3;

  logic        ap_clk;
  logic        reset;
  logic        write_valid;
  logic        write_ready;
  logic [29:0] write_addr;
  logic [31:0] write_wdata;
  logic [3:0]  write_wstrb;
  logic        write_done;
  logic        write_error;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [0:0]  m_axi_awid;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic [3:0]  m_axi_awqos;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic [0:0]  m_axi_bid;

  write_channel_axi #(.CACHE_WRITE_MAX_RETRY(MAX_RETRY)) dut (
    .ap_clk(ap_clk), .reset(reset),
    .write_valid(write_valid), .write_ready(write_ready),
    .write_addr(write_addr), .write_wdata(write_wdata), .write_wstrb(write_wstrb),
    .write_done(write_done), .write_error(write_error),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bid(m_axi_bid)
  );

  typedef struct packed {
    logic [1:0] kind;   // {done, error}
    int         lat;    // expected accept-to-pulse cycles, 0 = unchecked
  } out_t;

  // Scoreboard queues: one AW/W entry per expected attempt, one outcome per write.
  logic [31:0] exp_aw[$];
  logic [35:0] exp_w[$];
  logic [1:0]  resp_q[$];
  out_t        out_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  // Slave behaviour: 0 always ready, 1 random, 2 stall everything, 3 fixed delays
  int mode = 0;
  int aw_dly = 0;
  int w_dly = 0;

  // Monitor/slave shared state
  logic        aw_pend = 0, w_pend = 0, b_pend = 0;
  logic        aw_seen = 0, w_seen = 0;
  logic        prev_awv = 0, prev_wv = 0, prev_pulse = 0;
  logic [31:0] prev_awaddr = '0, prev_wdata = '0;
  logic [3:0]  prev_wstrb = '0;
  int          aw_wait = 0, w_wait = 0;

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event not expected / not seen (cycle %0d)", nm, cyc);
  endtask

  task automatic monitor_step();
    logic [31:0] ea;
    logic [35:0] ew;
    out_t        o;
    if (reset) begin
      prev_awv = 0; prev_wv = 0; prev_pulse = 0;
      aw_pend = 0; w_pend = 0; b_pend = 0;
      return;
    end
    // A valid that was not accepted last cycle must persist with the same payload.
    if (prev_awv) chk("aw_hold", {m_axi_awvalid, m_axi_awaddr}, {1'b1, prev_awaddr});
    if (prev_wv)  chk("w_hold", {m_axi_wvalid, m_axi_wdata, m_axi_wstrb}, {1'b1, prev_wdata, prev_wstrb});
    prev_awv    = m_axi_awvalid && !m_axi_awready;
    prev_awaddr = m_axi_awaddr;
    prev_wv     = m_axi_wvalid && !m_axi_wready;
    prev_wdata  = m_axi_wdata;
    prev_wstrb  = m_axi_wstrb;

    if (m_axi_awvalid && m_axi_awready) begin
      if (exp_aw.size() == 0) note_fail("aw_unexpected");
      else begin
        ea = exp_aw.pop_front();
        chk("awaddr", m_axi_awaddr, ea);
      end
      chk("aw_const", {m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
                       m_axi_awcache, m_axi_awprot, m_axi_awqos},
                      {1'b0, 8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
      aw_pend = 1;
    end
    if (m_axi_wvalid && m_axi_wready) begin
      if (exp_w.size() == 0) note_fail("w_unexpected");
      else begin
        ew = exp_w.pop_front();
        chk("wdata_strb", {m_axi_wdata, m_axi_wstrb}, ew);
      end
      chk("wlast", m_axi_wlast, 1'b1);
      w_pend = 1;
    end
    if (m_axi_bready) chk("bready_early", {aw_seen, w_seen}, 2'b11);
    if (m_axi_bvalid && m_axi_bready) b_pend = 1;

    if (write_done || write_error) begin
      chk("pulse_excl", write_done & write_error, 1'b0);
      chk("ready_with_pulse", write_ready, 1'b1);
      chk("pulse_width", prev_pulse, 1'b0);
      if (out_q.size() == 0) note_fail("pulse_unexpected");
      else begin
        o = out_q.pop_front();
        chk("outcome", {write_done, write_error}, o.kind);
        if (o.lat != 0) chk("latency", cyc - acc_cyc, o.lat);
      end
    end
    prev_pulse = write_done | write_error;
  endtask

  task automatic slave_step();
    if (reset) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
      aw_seen = 0; w_seen = 0; aw_wait = 0; w_wait = 0;
      return;
    end
    if (aw_pend) begin aw_seen = 1; aw_pend = 0; end
    if (w_pend)  begin w_seen = 1;  w_pend = 0;  end
    if (b_pend)  begin m_axi_bvalid = 0; b_pend = 0; aw_seen = 0; w_seen = 0; end
    aw_wait = m_axi_awvalid ? aw_wait + 1 : 0;
    w_wait  = m_axi_wvalid  ? w_wait + 1  : 0;
    case (mode)
      0: begin m_axi_awready = 1; m_axi_wready = 1; end
      1: begin m_axi_awready = 1'($urandom_range(0, 1)); m_axi_wready = 1'($urandom_range(0, 1)); end
      2: begin m_axi_awready = 0; m_axi_wready = 0; end
      default: begin m_axi_awready = (aw_wait > aw_dly); m_axi_wready = (w_wait > w_dly); end
    endcase
    if (aw_seen && w_seen && !m_axi_bvalid && mode != 2 &&
        (mode != 1 || $urandom_range(0, 2) == 0)) begin
      m_axi_bvalid = 1;
      if (resp_q.size() == 0) begin
        note_fail("resp_underflow");
        m_axi_bresp = 2'b00;
      end else m_axi_bresp = resp_q.pop_front();
    end else if (!m_axi_bvalid) begin
      m_axi_bresp = 2'($urandom);
    end
  endtask

  initial begin : slave_monitor
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
    m_axi_bresp = 0; m_axi_bid = 0;
    forever begin
      @(negedge ap_clk);
      monitor_step();
      @(posedge ap_clk);
      #1;
      slave_step();
    end
  end

  // Issue one write; ne = number of error responses before an OKAY (ecode 0 = random codes).
  task automatic do_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int ne, input logic [1:0] ecode);
    int   n;
    int   att;
    logic [1:0] c;
    out_t o;
    @(posedge ap_clk); #1;
    write_valid = 1; write_addr = a; write_wdata = d; write_wstrb = s;
    n = 0;
    @(negedge ap_clk);
    while (!write_ready && n < 50) begin @(negedge ap_clk); n++; end
    if (!write_ready) begin
      note_fail("accept_timeout");
      write_valid = 0;
      return;
    end
    acc_cyc = cyc;
    att = (ne <= MAX_RETRY) ? ne + 1 : MAX_RETRY + 1;
    for (int i = 0; i < att; i++) begin
      exp_aw.push_back({a, 2'b00});
      exp_w.push_back({d, s});
      c = (ecode == 2'b00) ? 2'($urandom_range(1, 3)) : ecode;
      resp_q.push_back((i < ne) ? c : 2'b00);
    end
    o.kind = (ne <= MAX_RETRY) ? 2'b10 : 2'b01;
    o.lat  = (mode == 0) ? 1 + 2 * att : 0;
    out_q.push_back(o);
    @(posedge ap_clk); #1;
    // Scramble the request inputs: the DUT must use its registered copy.
    write_valid = 0;
    write_addr  = 30'($urandom);
    write_wdata = $urandom;
    write_wstrb = 4'($urandom);
    n = 0;
    while (out_q.size() != 0 && n < 400) begin @(negedge ap_clk); n++; end
    if (out_q.size() != 0) begin
      note_fail("done_timeout");
      exp_aw.delete(); exp_w.delete(); resp_q.delete(); out_q.delete();
    end
  endtask

  initial begin : stimulus
    int n;
    reset = 1; write_valid = 0; write_addr = '0; write_wdata = '0; write_wstrb = '0;
    repeat (2) @(negedge ap_clk);
    chk("reset_state", {write_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, write_done, write_error}, 6'b0);
    @(posedge ap_clk); #1;
    reset = 0;
    @(negedge ap_clk);
    chk("idle_ready", write_ready, 1'b1);

    // Basic write with an always-ready slave: done three cycles after accept.
    mode = 0;
    do_write(30'h0000_1234 >> 2, 32'hDEADBEEF, 4'hF, 0, 2'b00);
    // AW accepted late, W immediately.
    mode = 3; aw_dly = 4; w_dly = 0;
    do_write(30'($urandom), $urandom, 4'hF, 0, 2'b00);
    // W accepted late, AW immediately, partial strobe.
    mode = 3; aw_dly = 0; w_dly = 3;
    do_write(30'($urandom), $urandom, 4'b0101, 0, 2'b00);
    // Two SLVERR responses then OKAY.
    mode = 0;
    do_write(30'($urandom), $urandom, 4'hC, 2, 2'b10);
    // DECERR on every attempt: four issues then write_error.
    do_write(30'($urandom), $urandom, 4'h3, 4, 2'b11);
    // Next request after giving up is handled normally.
    do_write(30'($urandom), $urandom, 4'hF, 0, 2'b00);
    // Exactly MAX_RETRY errors still succeeds.
    do_write(30'($urandom), $urandom, 4'h9, MAX_RETRY, 2'b01);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      mode = ($urandom_range(0, 2) == 0) ? 0 : 1;
      do_write(30'($urandom), $urandom, 4'($urandom), $urandom_range(0, 5), 2'b00);
    end

    // Reset asserted mid-transaction while AW/W are stalled.
    mode = 2;
    @(posedge ap_clk); #1;
    write_valid = 1; write_addr = 30'($urandom); write_wdata = $urandom; write_wstrb = 4'hF;
    n = 0;
    @(negedge ap_clk);
    while (!write_ready && n < 50) begin @(negedge ap_clk); n++; end
    chk("rst_test_accept", write_ready, 1'b1);
    @(posedge ap_clk); #1;
    write_valid = 0;
    @(negedge ap_clk);
    chk("rst_pre_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    #2;
    reset = 1;
    #1;
    chk("rst_async", {m_axi_awvalid, m_axi_wvalid, write_ready, m_axi_bready, write_done, write_error}, 6'b0);
    repeat (3) @(posedge ap_clk);
    #1;
    reset = 0;
    mode = 0;
    @(negedge ap_clk);
    chk("rst_ready_after", write_ready, 1'b1);
    repeat (4) @(negedge ap_clk);
    do_write(30'($urandom), $urandom, 4'hF, 1, 2'b10);

    repeat (3) @(negedge ap_clk);
    chk("queues_drained", {32'(exp_aw.size()), 32'(exp_w.size())}, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    note_fail("global_timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "simulation timeout");
  end

endmodule
